// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch unit: FSM encodings, reset vector and next-PC select codes.
package fetch_unit_pkg;

    localparam logic [0:0] FETCH_IDLE = 1'b0;
    localparam logic [0:0] FETCH_REQ  = 1'b1;

    localparam logic [31:2] RESET_PC_DEFAULT = 30'h0000_0C00;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_JREG   = 2'b11
    } npc_sel_e;

    // Unsigned wrap makes addresses below base land far above any window size.
    function automatic logic in_imem_window(input logic [29:0] addr,
                                            input logic [29:0] base,
                                            input logic [29:0] words);
        logic [29:0] offset;
        offset = addr - base;
        return (offset < words);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
interface fetch_unit_if;

    logic        imem_req;
    logic [31:2] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_unit.sv
// PC register, IR register and two-state fetch FSM of the multicycle MIPS core.
// Optional macro FETCH_TIMEOUT_EN adds a bounded wait for imem_ack that faults on expiry.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:2] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_WORDS = 1024
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pc_wr,
    input  logic [31:2]  npc,
    input  logic         fetch_start,
    fetch_unit_if.master imem,
    output logic [31:2]  pc,
    output logic [31:0]  ir,
    output logic         ir_valid,
    output logic         turn,
    output logic         fetch_busy,
    output logic         fetch_fault
);

    logic [0:0]  state_q,    state_d;
    logic [31:2] pc_q,       pc_d;
    logic [31:0] ir_q,       ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic        turn_q,     turn_d;
    logic        req_q,      req_d;
    logic [31:2] addr_q,     addr_d;
    logic        fault_q,    fault_d;

    logic [31:2] pc_sel_s;
    logic        in_range_s;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // A same-cycle pc_wr in IDLE redirects the fetch address as well as pc.
    always_comb begin
        if ((state_q == FETCH_IDLE) && pc_wr) begin
            pc_sel_s = npc;
        end else begin
            pc_sel_s = pc_q;
        end
    end

    assign in_range_s = in_imem_window(pc_sel_s, RESET_PC, 30'(IMEM_WORDS));

    // Next-state logic for the FSM and every architectural register.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        turn_d     = 1'b0;
        req_d      = req_q;
        addr_d     = addr_q;
        fault_d    = fault_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            FETCH_IDLE: begin
                pc_d = pc_sel_s;
                if (fetch_start && !fault_q) begin
                    if (in_range_s) begin
                        state_d    = FETCH_REQ;
                        req_d      = 1'b1;
                        addr_d     = pc_sel_s;
                        ir_valid_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
                        cnt_d      = '0;
`endif
                    end else begin
                        fault_d = 1'b1;
                    end
                end else begin
                    state_d = FETCH_IDLE;
                end
            end
            FETCH_REQ: begin
                // pc must not move under an outstanding fetch; flag the controller bug.
                if (pc_wr) begin
                    fault_d = 1'b1;
                end else begin
                    fault_d = fault_q;
                end
                if (imem.imem_ack) begin
                    ir_d       = imem.imem_rdata;
                    ir_valid_d = 1'b1;
                    turn_d     = 1'b1;
                    req_d      = 1'b0;
                    state_d    = FETCH_IDLE;
`ifdef FETCH_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    fault_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = FETCH_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                end else begin
                    state_d = FETCH_REQ;
                end
`endif
            end
            default: begin
                state_d = FETCH_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= 32'h0000_0000;
            ir_valid_q <= 1'b0;
            turn_q     <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= 30'h0000_0000;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            turn_q     <= turn_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fault_q    <= fault_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Wait counter for the outstanding request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign pc             = pc_q;
    assign ir             = ir_q;
    assign ir_valid       = ir_valid_q;
    assign turn           = turn_q;
    assign fetch_busy     = (state_q != FETCH_IDLE);
    assign fetch_fault    = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit plus hand sequences for timeout and async reset.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        pc_wr;
    logic [31:2] npc;
    logic        fetch_start;
    logic [31:2] pc;
    logic [31:0] ir;
    logic        ir_valid;
    logic        turn;
    logic        fetch_busy;
    logic        fetch_fault;

    fetch_unit_if imem_bus ();

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .pc_wr       (pc_wr),
        .npc         (npc),
        .fetch_start (fetch_start),
        .imem        (imem_bus),
        .pc          (pc),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .turn        (turn),
        .fetch_busy  (fetch_busy),
        .fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        pc_wr;
        logic [31:2] npc;
        logic        start;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:2] e_addr;
        logic [31:2] e_pc;
        logic [31:0] e_ir;
        logic        e_v;
        logic        e_turn;
        logic        e_busy;
        logic        e_fault;
    } vec_t;

    localparam logic [31:2] JUNK_NPC   = 30'h3FFF_FFFF;
    localparam logic [31:0] JUNK_RDATA = 32'hA5A5_A5A5;

    vec_t vecs[$];
    int   tests;
    int   fails;

    task automatic add(input logic r, input logic w, input logic [31:2] n, input logic s,
                       input logic a, input logic [31:0] d,
                       input logic eq, input logic [31:2] ea, input logic [31:2] ep,
                       input logic [31:0] ei, input logic ev, input logic et,
                       input logic eb, input logic ef);
        vec_t v;
        v.rst = r; v.pc_wr = w; v.npc = n; v.start = s; v.ack = a; v.rdata = d;
        v.e_req = eq; v.e_addr = ea; v.e_pc = ep; v.e_ir = ei;
        v.e_v = ev; v.e_turn = et; v.e_busy = eb; v.e_fault = ef;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] outs_now();
        return {31'd0, imem_bus.imem_req, imem_bus.imem_addr, pc, ir,
                ir_valid, turn, fetch_busy, fetch_fault};
    endfunction

    task automatic drive(input logic r, input logic w, input logic [31:2] n, input logic s,
                         input logic a, input logic [31:0] d);
        rst = r; pc_wr = w; npc = n; fetch_start = s;
        imem_bus.imem_ack = a; imem_bus.imem_rdata = d;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        drive(1'b1, 1'b0, JUNK_NPC, 1'b0, 1'b0, JUNK_RDATA);

        //   rst   wr    npc            st    ack   rdata           req   addr           pc             ir              v     t     busy  flt
        add(1'b1, 1'b0, JUNK_NPC,      1'b0, 1'b0, JUNK_RDATA,     1'b0, 30'h0000,      30'h0C00,      32'h0000_0000,  1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, JUNK_NPC,      1'b0, 1'b0, JUNK_RDATA,     1'b0, 30'h0000,      30'h0C00,      32'h0000_0000,  1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, JUNK_NPC,      1'b1, 1'b0, JUNK_RDATA,     1'b1, 30'h0C00,      30'h0C00,      32'h0000_0000,  1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, JUNK_NPC,      1'b0, 1'b1, 32'h2008_0005,  1'b0, 30'h0C00,      30'h0C00,      32'h2008_0005,  1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, JUNK_NPC,      1'b0, 1'b0, JUNK_RDATA,     1'b0, 30'h0C00,      30'h0C00,      32'h2008_0005,  1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, JUNK_NPC,      1'b0, 1'b1, 32'hDEAD_BEEF,  1'b0, 30'h0C00,      30'h0C00,      32'h2008_0005,  1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 30'h0C05,      1'b1, 1'b0, JUNK_RDATA,     1'b1, 30'h0C05,      30'h0C05,      32'h2008_0005,  1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, JUNK_NPC,      1'b0, 1'b1, 32'h0800_0C00,  1'b0, 30'h0C05,      30'h0C05,      32'h0800_0C00,  1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, JUNK_NPC,      1'b1, 1'b0, JUNK_RDATA,     1'b1, 30'h0C05,      30'h0C05,      32'h0800_0C00,  1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, JUNK_NPC,      1'b1, 1'b0, JUNK_RDATA,     1'b1, 30'h0C05,      30'h0C05,      32'h0800_0C00,  1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 30'h0D00,      1'b0, 1'b0, JUNK_RDATA,     1'b1, 30'h0C05,      30'h0C05,      32'h0800_0C00,  1'b0, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b0, JUNK_NPC,      1'b0, 1'b0, JUNK_RDATA,     1'b1, 30'h0C05,      30'h0C05,      32'h0800_0C00,  1'b0, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b0, JUNK_NPC,      1'b0, 1'b0, JUNK_RDATA,     1'b1, 30'h0C05,      30'h0C05,      32'h0800_0C00,  1'b0, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b0, JUNK_NPC,      1'b0, 1'b1, 32'h1234_5678,  1'b0, 30'h0C05,      30'h0C05,      32'h1234_5678,  1'b1, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b0, JUNK_NPC,      1'b1, 1'b0, JUNK_RDATA,     1'b0, 30'h0C05,      30'h0C05,      32'h1234_5678,  1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, JUNK_NPC,      1'b0, 1'b0, JUNK_RDATA,     1'b0, 30'h0000,      30'h0C00,      32'h0000_0000,  1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 30'h0FFF,      1'b1, 1'b0, JUNK_RDATA,     1'b1, 30'h0FFF,      30'h0FFF,      32'h0000_0000,  1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, JUNK_NPC,      1'b0, 1'b1, 32'h0000_000C,  1'b0, 30'h0FFF,      30'h0FFF,      32'h0000_000C,  1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 30'h1000,      1'b0, 1'b0, JUNK_RDATA,     1'b0, 30'h0FFF,      30'h1000,      32'h0000_000C,  1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, JUNK_NPC,      1'b1, 1'b0, JUNK_RDATA,     1'b0, 30'h0FFF,      30'h1000,      32'h0000_000C,  1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 30'h0C00,      1'b0, 1'b0, JUNK_RDATA,     1'b0, 30'h0FFF,      30'h0C00,      32'h0000_000C,  1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, JUNK_NPC,      1'b1, 1'b0, JUNK_RDATA,     1'b0, 30'h0FFF,      30'h0C00,      32'h0000_000C,  1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, JUNK_NPC,      1'b0, 1'b0, JUNK_RDATA,     1'b0, 30'h0000,      30'h0C00,      32'h0000_0000,  1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 30'h0BFF,      1'b1, 1'b0, JUNK_RDATA,     1'b0, 30'h0000,      30'h0BFF,      32'h0000_0000,  1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, JUNK_NPC,      1'b0, 1'b0, JUNK_RDATA,     1'b0, 30'h0000,      30'h0C00,      32'h0000_0000,  1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].pc_wr, vecs[i].npc, vecs[i].start, vecs[i].ack, vecs[i].rdata);
            @(negedge clk);
            chk($sformatf("row%0d", i), outs_now(),
                {31'd0, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_pc, vecs[i].e_ir,
                 vecs[i].e_v, vecs[i].e_turn, vecs[i].e_busy, vecs[i].e_fault});
        end

        // Prime ir with a known word, then start a fetch that never gets acknowledged.
        drive(1'b0, 1'b0, JUNK_NPC, 1'b1, 1'b0, JUNK_RDATA);
        @(negedge clk);
        drive(1'b0, 1'b0, JUNK_NPC, 1'b0, 1'b1, 32'h2008_0005);
        @(negedge clk);
        chk("prime_ir", {96'd0, ir}, {96'd0, 32'h2008_0005});
        drive(1'b0, 1'b0, JUNK_NPC, 1'b1, 1'b0, JUNK_RDATA);
        @(negedge clk);
        drive(1'b0, 1'b0, JUNK_NPC, 1'b0, 1'b0, JUNK_RDATA);
`ifdef FETCH_TIMEOUT_EN
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            chk($sformatf("tmo_wait%0d", k), {127'd0, imem_bus.imem_req}, {127'd0, 1'b1});
        end
        @(negedge clk);
        chk("tmo_expire", {91'd0, imem_bus.imem_req, ir, ir_valid, fetch_busy, fetch_fault},
                          {91'd0, 1'b0, 32'h2008_0005, 1'b0, 1'b0, 1'b1});
`else
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
        end
        chk("no_tmo_wait", {124'd0, imem_bus.imem_req, fetch_busy, fetch_fault, ir_valid},
                           {124'd0, 1'b1, 1'b1, 1'b0, 1'b0});
        drive(1'b0, 1'b0, JUNK_NPC, 1'b0, 1'b1, 32'h0000_0055);
        @(negedge clk);
        chk("no_tmo_ack", {94'd0, ir, ir_valid, turn}, {94'd0, 32'h0000_0055, 1'b1, 1'b1});
`endif

        // Reset asserted while a request is outstanding; a late ack must be dropped.
        drive(1'b1, 1'b0, JUNK_NPC, 1'b0, 1'b0, JUNK_RDATA);
        @(negedge clk);
        drive(1'b0, 1'b1, 30'h0C05, 1'b1, 1'b0, JUNK_RDATA);
        @(negedge clk);
        chk("rst_pre_req", {127'd0, imem_bus.imem_req}, {127'd0, 1'b1});
        drive(1'b0, 1'b0, JUNK_NPC, 1'b0, 1'b0, JUNK_RDATA);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", {94'd0, imem_bus.imem_req, pc, ir_valid, fetch_busy},
                         {94'd0, 1'b0, 30'h0C00, 1'b0, 1'b0});
        @(negedge clk);
        drive(1'b0, 1'b0, JUNK_NPC, 1'b0, 1'b1, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("rst_late_ack", {93'd0, imem_bus.imem_req, ir, ir_valid, turn},
                            {93'd0, 1'b0, 32'h0000_0000, 1'b0, 1'b0});
        drive(1'b0, 1'b0, JUNK_NPC, 1'b0, 1'b0, JUNK_RDATA);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch end of the next-PC path in the multicycle MIPS core.
- Holds the architectural PC register and loads it from the next-PC computation unit's NPC output on the controller's write strobe.
- Fetches the instruction at PC from instruction memory through a req/ack handshake and latches IR.
- Pulses `turn` back to the next-PC unit so PC+4 is sampled once per fetched instruction.

Parameters:
- RESET_PC, 30'h0C00, word address loaded at reset (byte address 0x0000_3000).
- IMEM_WORDS, 1024, size of the legal instruction window starting at RESET_PC, in words.
- TIMEOUT_CYCLES, 16, maximum wait for imem_ack before a fetch fault (only with FETCH_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc_wr  input  1  controller strobe: load pc from npc.
- npc  input  [31:2]  next PC from the next-PC unit.
- fetch_start  input  1  controller request to fetch the instruction at pc.
- imem_req  output  1  instruction memory request.
- imem_addr  output  [31:2]  instruction memory word address.
- imem_ack  input  1  memory has returned data this cycle.
- imem_rdata  input  [31:0]  instruction word, valid when imem_ack=1.
- pc  output  [31:2]  current PC, fed to the next-PC unit's PC input.
- ir  output  [31:0]  latched instruction; [25:0] feeds the next-PC unit's immediate input.
- ir_valid  output  1  ir holds a completed fetch.
- turn  output  1  one-cycle pulse on fetch completion; drives the next-PC unit's turn input.
- fetch_busy  output  1  FSM is not in IDLE.
- fetch_fault  output  1  sticky fault flag.

Behaviour:
- Reset (asynchronous):
  - pc=RESET_PC, ir=0, ir_valid=0, turn=0, imem_req=0, imem_addr=0, fetch_fault=0.
  - FSM enters IDLE; timeout counter=0.
- FSM states: IDLE, REQ.
- IDLE behaviour:
  - pc_wr=1 loads pc<=npc.
  - fetch_start=1 (with fetch_fault=0) checks range on the value pc holds after any same-cycle pc_wr.
  - In range, i.e. (pc_next - RESET_PC) < IMEM_WORDS as unsigned 30-bit arithmetic (wraps below RESET_PC, so those addresses count as out of range):
    - go to REQ; imem_req<=1; imem_addr<=pc_next; ir_valid<=0.
  - Out of range: fetch_fault<=1, stay in IDLE, no request is issued.
  - Simultaneous pc_wr and fetch_start: the new npc is used for both the fetch and pc.
- REQ behaviour:
  - imem_req and imem_addr are held stable until the ack.
  - imem_ack=1:
    - ir<=imem_rdata, ir_valid<=1, turn<=1 for exactly one cycle, imem_req<=0.
    - Return to IDLE.
  - Minimum latency: fetch_start to ir_valid is 2 cycles when ack arrives in the first REQ cycle.
  - pc_wr in REQ: ignored (pc unchanged); fetch_fault<=1.
  - fetch_start in REQ: ignored.
- fetch_fault:
  - Sticky until rst.
  - While it is set, fetch_start is ignored; pc_wr still works.
- ir holds its value across faults and is changed only by an ack.
- imem_ack outside REQ: ignored.
- turn is 0 in every cycle except the one after an accepted ack.
- Reset asserted mid-REQ: imem_req drops immediately (asynchronously); any later ack is ignored.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on REQ entry and increments each REQ cycle without an ack.
  - When it reaches TIMEOUT_CYCLES-1 without an ack: fetch_fault<=1, imem_req<=0, return to IDLE, ir and ir_valid unchanged (ir_valid stays 0).
  - An ack on that same cycle wins over the timeout.
- Undefined: no counter; REQ waits indefinitely.

Decomposition:
- Shared header constants:
  - FSM state encodings FETCH_IDLE=1'b0, FETCH_REQ=1'b1.
  - Reset-vector default 30'h0C00, alongside the existing jump encodings.
- No sub-module is needed: the PC register, IR register and FSM sit in one module.
- Range check is a single combinational compare.

Test Plan:
- Reset then fetch_start, ack on the 1st REQ cycle with rdata=0x2008_0005:
  - imem_addr=30'h0C00.
  - ir=0x2008_0005 and ir_valid=1 two cycles after fetch_start.
  - turn high for exactly one cycle.
- pc_wr=1 with npc=30'h0C05 in the same cycle as fetch_start:
  - imem_addr=30'h0C05 and pc=30'h0C05.
  - ack with rdata=0x0800_0C00 → ir=0x0800_0C00.
- Ack delayed 5 cycles:
  - imem_req and imem_addr stay stable throughout.
  - pc_wr pulsed mid-REQ → pc unchanged, fetch_fault=1, fetch still completes.
- pc_wr with npc=30'h0C00+1024, then fetch_start:
  - No imem_req, fetch_fault=1.
  - A later in-range fetch_start is ignored until rst.
- With FETCH_TIMEOUT_EN, no ack:
  - imem_req drops after 16 REQ cycles, fetch_fault=1.
  - ir retains its previous value 0x2008_0005, ir_valid=0.
- rst asserted during REQ:
  - Immediately imem_req=0, pc=30'h0C00, ir_valid=0.
  - A later ack has no effect.
